// File: rtl/proc_pkg.sv
// Shared processor constants: bus register indices
// and default datapath widths.
package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 4;
  localparam int N_REGS_DEF = 11;

  localparam int REG_AR = 0;
  localparam int REG_DR = 1;
  localparam int REG_R1 = 2;
  localparam int REG_R2 = 3;
  localparam int REG_R3 = 4;
  localparam int REG_RA = 5;
  localparam int REG_RB = 6;
  localparam int REG_RC = 7;
  localparam int REG_AC = 8;
  localparam int REG_TR = 9;
  localparam int REG_IR = 10;

endpackage

// File: rtl/bus_reg_cell.sv
// One datapath register with clear > load > increment
// priority; exposes its next value for read bypass.
module bus_reg_cell #(
  parameter int                DATA_W  = 16,
  parameter bit                INC_EN  = 1'b0,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic              inc,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] nxt
);

  // Resolve next value; increment wraps naturally.
  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = RST_VAL;
    end else if (ld) begin
      nxt = d;
    end else if (inc && INC_EN) begin
      nxt = q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bus_reg_bank.sv
// Bus-loaded register bank: write decode, per-register
// clr/inc, bypassed registered read-back, ack/err pulses.
module bus_reg_bank
  import proc_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                N_REGS   = N_REGS_DEF,
  parameter int                SEL_W    = SEL_W_DEF,
  parameter logic [N_REGS-1:0] INC_MASK = 11'h011,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_REGS-1:0]        inc_en,
  input  logic [N_REGS-1:0]        clr_en,
  input  logic [SEL_W-1:0]         rd_sel,
  output logic [DATA_W-1:0]        rd_data,
  output logic [N_REGS*DATA_W-1:0] regs_flat,
  output logic                     wr_ack,
  output logic                     wr_err
);

  localparam logic [SEL_W:0] NREG_L = (SEL_W+1)'(N_REGS);

  logic [N_REGS-1:0] ld;
  logic [DATA_W-1:0] q   [N_REGS];
  logic [DATA_W-1:0] nxt [N_REGS];
  logic [DATA_W-1:0] rd_nxt;
  logic              sel_ok;

  assign sel_ok = ({1'b0, wr_sel} < NREG_L);

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    assign ld[i] = wr_en && (wr_sel == SEL_W'(i));
    assign regs_flat[i*DATA_W +: DATA_W] = q[i];

    bus_reg_cell #(
      .DATA_W  (DATA_W),
      .INC_EN  (INC_MASK[i]),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_en[i]),
      .ld    (ld[i]),
      .inc   (inc_en[i]),
      .d     (wr_data),
      .q     (q[i]),
      .nxt   (nxt[i])
    );
  end

  // Read mux over post-edge values; out of range reads 0.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_nxt = nxt[i];
      end
    end
  end

  // Registered read-back and write status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= RST_VAL;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      rd_data <= rd_nxt;
      wr_ack  <= wr_en && sel_ok;
      wr_err  <= wr_en && !sel_ok;
    end
  end

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed bench for bus_reg_bank with a queued
// scoreboard checked by an independent monitor.
module tb_bus_reg_bank;
  import proc_pkg::*;

  localparam int DW = 16;
  localparam int NR = 11;

  typedef struct {
    string             name;
    logic              ack;
    logic              err;
    logic [DW-1:0]     rd;
    logic [NR*DW-1:0]  regs;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [3:0]        wr_sel;
  logic [DW-1:0]     wr_data;
  logic [NR-1:0]     inc_en;
  logic [NR-1:0]     clr_en;
  logic [3:0]        rd_sel;
  logic [DW-1:0]     rd_data;
  logic [NR*DW-1:0]  regs_flat;
  logic              wr_ack;
  logic              wr_err;

  exp_t          exp_q[$];
  logic [DW-1:0] e [NR];
  int            checks;
  int            errors;

  bus_reg_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .inc_en    (inc_en),
    .clr_en    (clr_en),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .regs_flat (regs_flat),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [NR*DW-1:0] act,
                     input logic [NR*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = e[i];
    return f;
  endfunction

  task automatic idle_in();
    wr_en   = 1'b0;
    wr_sel  = '0;
    wr_data = '0;
    inc_en  = '0;
    clr_en  = '0;
    rd_sel  = '0;
  endtask

  // Drive one cycle at negedge; e[] already holds the
  // hand-set post-edge register values.
  task automatic step(input string nm,
                      input logic we,
                      input logic [3:0] ws,
                      input logic [DW-1:0] wd,
                      input logic [NR-1:0] inc,
                      input logic [NR-1:0] clr,
                      input logic [3:0] rs,
                      input logic xa,
                      input logic xe,
                      input logic [DW-1:0] xr);
    exp_t x;
    @(negedge clk);
    wr_en   = we;
    wr_sel  = ws;
    wr_data = wd;
    inc_en  = inc;
    clr_en  = clr;
    rd_sel  = rs;
    x.name = nm;
    x.ack  = xa;
    x.err  = xe;
    x.rd   = xr;
    x.regs = flat();
    exp_q.push_back(x);
  endtask

  // Monitor: after every edge, compare the oldest
  // pending expectation with what the DUT presents.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk({x.name, "_ack"}, NR*DW'(wr_ack), NR*DW'(x.ack));
        chk({x.name, "_err"}, NR*DW'(wr_err), NR*DW'(x.err));
        chk({x.name, "_rd"}, NR*DW'(rd_data), NR*DW'(x.rd));
        chk({x.name, "_regs"}, regs_flat, x.regs);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NR; i++) e[i] = '0;
    idle_in();
    rst_n = 1'b0;

    // 1: reset held while inputs toggle
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_sel  = 4'(k + 8);
      wr_data = 16'h5A5A ^ 16'(k);
      inc_en  = '1;
      clr_en  = '0;
      rd_sel  = 4'(k);
    end
    @(negedge clk);
    chk("rst_regs", regs_flat, '0);
    chk("rst_rd", NR*DW'(rd_data), '0);
    chk("rst_ack", NR*DW'(wr_ack), '0);
    chk("rst_err", NR*DW'(wr_err), '0);
    idle_in();
    rst_n = 1'b1;

    // 2: write IR
    e[REG_IR] = 16'hBEEF;
    step("wr_ir", 1, 4'd10, 16'hBEEF, '0, '0, 4'd10,
         1, 0, 16'hBEEF);

    // 3: priority
    e[REG_AR] = 16'h0005;
    step("ar_5", 1, 4'd0, 16'h0005, '0, '0, 4'd0,
         1, 0, 16'h0005);
    e[REG_AR] = 16'h1234;
    step("ld_over_inc", 1, 4'd0, 16'h1234, 11'h001, '0,
         4'd0, 1, 0, 16'h1234);
    e[REG_AR] = 16'h0000;
    step("clr_over_ld", 1, 4'd0, 16'h1234, 11'h001,
         11'h001, 4'd0, 1, 0, 16'h0000);

    // 4: wrap and masked increment
    e[REG_AR] = 16'hFFFF;
    step("ar_ffff", 1, 4'd0, 16'hFFFF, '0, '0, 4'd0,
         1, 0, 16'hFFFF);
    e[REG_AR] = 16'h0000;
    step("inc_wrap", 0, 4'd0, 16'h0000, 11'h001, '0,
         4'd0, 0, 0, 16'h0000);
    e[REG_DR] = 16'h0007;
    step("dr_7", 1, 4'd1, 16'h0007, '0, '0, 4'd1,
         1, 0, 16'h0007);
    step("inc_masked", 0, 4'd0, 16'h0000, 11'h002, '0,
         4'd1, 0, 0, 16'h0007);
    e[REG_AR] = 16'h0001;
    e[REG_R3] = 16'h0001;
    step("inc_multi", 0, 4'd0, 16'h0000, 11'h7FF, '0,
         4'd4, 0, 0, 16'h0001);

    // 5: invalid select
    step("wr_bad_sel", 1, 4'hC, 16'hAAAA, '0, '0, 4'd10,
         0, 1, 16'hBEEF);
    step("rd_bad_sel", 0, 4'd0, 16'h0000, '0, '0, 4'hF,
         0, 0, 16'h0000);
    e[REG_AR] = 16'h0000;
    e[REG_IR] = 16'h0000;
    step("clr_multi", 0, 4'd0, 16'h0000, '0, 11'h401,
         4'd10, 0, 0, 16'h0000);

    // 6: reset asserted before the edge of a write
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = 4'd8;
    wr_data = 16'h00FF;
    rd_sel  = 4'd8;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_regs", regs_flat, '0);
    chk("mid_rst_ack", NR*DW'(wr_ack), '0);
    idle_in();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) e[i] = '0;
    step("post_rst", 0, 4'd0, 16'h0000, '0, '0, 4'd8,
         0, 0, 16'h0000);
    e[REG_AC] = 16'h0042;
    step("wr_ac", 1, 4'd8, 16'h0042, '0, '0, 4'd8,
         1, 0, 16'h0042);
    step("hold_ac", 0, 4'd0, 16'h0000, 11'h100, '0,
         4'd8, 0, 0, 16'h0042);

    @(negedge clk);
    idle_in();
    @(negedge clk);
    chk("queue_drained", NR*DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
